// File: rtl/flow_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flow_seq_pkg
// Description : Shared encodings for the flow-control sequencer: flow opcode,
//               subcodes, FSM states, pc_src and sp_op selectors.
// Revision    : 1.0 - initial release
// ============================================================================
package flow_seq_pkg;

    localparam logic [3:0] c_FLOW_OPCODE = 4'hB;

    typedef enum logic [1:0] {
        SUB_JMP  = 2'b00,
        SUB_CALL = 2'b01,
        SUB_RET  = 2'b10,
        SUB_RTI  = 2'b11
    } flow_sub_t;

    // Interrupt states exist only when the interrupt path is built in.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CALL_TGT = 3'd1,
        ST_RET_WAIT = 3'd2,
        ST_RET_LOAD = 3'd3
`ifdef FLOW_INTR_EN
        ,
        ST_INT_VEC  = 3'd4,
        ST_INT_LOAD = 3'd5
`endif
    } state_t;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_JUMP = 2'b01,
        PC_MEM  = 2'b10,
        PC_HOLD = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        SP_NONE = 2'b00,
        SP_PUSH = 2'b01,
        SP_POP  = 2'b10
    } sp_op_t;

    function automatic logic is_flow_opcode(input logic [3:0] opcode);
        return opcode == c_FLOW_OPCODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flow_seq_intr_sync.sv
`default_nettype none
// ============================================================================
// Module      : intr_sync
// Description : Two-flop synchronizer bringing the external interrupt request
//               into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/flow_seq.sv
`default_nettype none
// ============================================================================
// Module      : flow_seq
// Description : Flow-control sequencer for JMP/CALL/RET/RTI and interrupt
//               entry. Interrupt path built only with FLOW_INTR_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_seq
    import flow_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] IR,
    input  logic       stall_d,
    input  logic       intr_req,
    output logic       stall_f,
    output logic       flush_d,
    output logic [1:0] pc_src,
    output logic [1:0] sp_op,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic       mem_addr_sel,
    output logic       flag_save,
    output logic       flag_restore,
    output logic       intr_ack,
    output logic       busy
);

    state_t    r_state;
    state_t    w_state_next;
    flow_sub_t w_sub;
    logic      w_is_flow;
    logic      w_accept;
    logic      w_unused_bits;

    assign w_is_flow = is_flow_opcode(IR[7:4]);
    assign w_sub     = flow_sub_t'(IR[3:2]);
    assign w_accept  = (r_state == ST_IDLE) && w_is_flow && !stall_d;

`ifdef FLOW_INTR_EN
    logic r_in_isr;
    logic r_is_rti;
    logic w_intr_sync;
    logic w_take_intr;
    logic w_set_isr;
    logic w_clr_isr;

    intr_sync u_intr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (intr_req),
        .sync_out (w_intr_sync)
    );

    // A flow instruction in decode always wins; the interrupt retries later.
    assign w_take_intr = (r_state == ST_IDLE) && w_intr_sync && !r_in_isr &&
                         !w_is_flow && !stall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_isr <= 1'b0;
            r_is_rti <= 1'b0;
        end else begin
            if (w_accept)
                r_is_rti <= (w_sub == SUB_RTI);
            if (w_set_isr)
                r_in_isr <= 1'b1;
            else if (w_clr_isr)
                r_in_isr <= 1'b0;
        end
    end

    assign w_unused_bits = ^IR[1:0];
`else
    assign w_unused_bits = ^{intr_req, IR[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Outputs are held at zero combinationally while reset is asserted.
    always_comb begin
        w_state_next = r_state;
        stall_f      = 1'b0;
        flush_d      = 1'b0;
        pc_src       = PC_INC;
        sp_op        = SP_NONE;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        mem_addr_sel = 1'b0;
        flag_save    = 1'b0;
        flag_restore = 1'b0;
        intr_ack     = 1'b0;
        busy         = (r_state != ST_IDLE);
`ifdef FLOW_INTR_EN
        w_set_isr    = 1'b0;
        w_clr_isr    = 1'b0;
`endif
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_sub)
                            SUB_JMP: begin
                                pc_src  = PC_JUMP;
                                flush_d = 1'b1;
                            end
                            SUB_CALL: begin
                                stall_f      = 1'b1;
                                mem_wr       = 1'b1;
                                sp_op        = SP_PUSH;
                                w_state_next = ST_CALL_TGT;
                            end
                            default: begin
                                stall_f      = 1'b1;
                                mem_rd       = 1'b1;
                                sp_op        = SP_POP;
                                w_state_next = ST_RET_WAIT;
                            end
                        endcase
                    end
`ifdef FLOW_INTR_EN
                    else if (w_take_intr) begin
                        stall_f      = 1'b1;
                        mem_wr       = 1'b1;
                        sp_op        = SP_PUSH;
                        flag_save    = 1'b1;
                        intr_ack     = 1'b1;
                        w_state_next = ST_INT_VEC;
                    end
`endif
                end
                ST_CALL_TGT: begin
                    pc_src       = PC_JUMP;
                    flush_d      = 1'b1;
                    w_state_next = ST_IDLE;
                end
                ST_RET_WAIT: begin
                    stall_f      = 1'b1;
                    w_state_next = ST_RET_LOAD;
                end
                ST_RET_LOAD: begin
                    pc_src       = PC_MEM;
                    flush_d      = 1'b1;
                    w_state_next = ST_IDLE;
`ifdef FLOW_INTR_EN
                    if (r_is_rti) begin
                        flag_restore = 1'b1;
                        w_clr_isr    = 1'b1;
                    end
`endif
                end
`ifdef FLOW_INTR_EN
                ST_INT_VEC: begin
                    stall_f      = 1'b1;
                    mem_rd       = 1'b1;
                    mem_addr_sel = 1'b1;
                    w_state_next = ST_INT_LOAD;
                end
                ST_INT_LOAD: begin
                    pc_src       = PC_MEM;
                    flush_d      = 1'b1;
                    w_set_isr    = 1'b1;
                    w_state_next = ST_IDLE;
                end
`endif
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flow_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_seq
// Description : Scoreboard bench for flow_seq: directed and random stimulus
//               against a step-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_flow_seq;

`ifdef FLOW_INTR_EN
    localparam bit c_INTR_EN = 1'b1;
`else
    localparam bit c_INTR_EN = 1'b0;
`endif

    // Layout: stall_f flush_d pc_src sp_op mem_wr mem_rd addr_sel
    //         flag_save flag_restore intr_ack busy
    localparam logic [12:0] c_E_JMP   = 13'b0_1_01_00_0_0_0_0_0_0_0;
    localparam logic [12:0] c_E_CALL0 = 13'b1_0_00_01_1_0_0_0_0_0_0;
    localparam logic [12:0] c_E_CALL1 = 13'b0_1_01_00_0_0_0_0_0_0_1;
    localparam logic [12:0] c_E_RET0  = 13'b1_0_00_10_0_1_0_0_0_0_0;
    localparam logic [12:0] c_E_RET1  = 13'b1_0_00_00_0_0_0_0_0_0_1;
    localparam logic [12:0] c_E_RET2  = 13'b0_1_10_00_0_0_0_0_0_0_1;
    localparam logic [12:0] c_E_RTI2  = 13'b0_1_10_00_0_0_0_0_1_0_1;
    localparam logic [12:0] c_E_INT0  = 13'b1_0_00_01_1_0_0_1_0_1_0;
    localparam logic [12:0] c_E_INT1  = 13'b1_0_00_00_0_1_1_0_0_0_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] IR = 8'h00;
    logic       stall_d = 1'b0;
    logic       intr_req = 1'b0;
    logic       stall_f, flush_d, mem_wr, mem_rd, mem_addr_sel;
    logic       flag_save, flag_restore, intr_ack, busy;
    logic [1:0] pc_src, sp_op;

    flow_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IR           (IR),
        .stall_d      (stall_d),
        .intr_req     (intr_req),
        .stall_f      (stall_f),
        .flush_d      (flush_d),
        .pc_src       (pc_src),
        .sp_op        (sp_op),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_addr_sel (mem_addr_sel),
        .flag_save    (flag_save),
        .flag_restore (flag_restore),
        .intr_ack     (intr_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] o;
        logic        set_isr;
        logic        clr_isr;
    } step_t;

    step_t       plan[$];
    logic [12:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        m_in_isr = 1'b0;
    logic        m_h1 = 1'b0;
    logic        m_h2 = 1'b0;

    wire [12:0] act = {stall_f, flush_d, pc_src, sp_op, mem_wr, mem_rd,
                       mem_addr_sel, flag_save, flag_restore, intr_ack, busy};

    function automatic step_t mk(input logic [12:0] o, input logic s, input logic c);
        step_t t;
        t.o = o;
        t.set_isr = s;
        t.clr_isr = c;
        return t;
    endfunction

    // Each accepted operation queues its whole remaining cycle sequence.
    task automatic model_cycle(input logic [7:0] ir, input logic st, input logic irq,
                               output logic [12:0] e);
        step_t s;
        logic  flow;
        flow = (ir[7:4] == 4'hB);
        s = mk(13'd0, 1'b0, 1'b0);
        if (plan.size() > 0) begin
            s = plan.pop_front();
        end else if (flow && !st) begin
            if (ir[3:2] == 2'b00) begin
                s.o = c_E_JMP;
            end else if (ir[3:2] == 2'b01) begin
                s.o = c_E_CALL0;
                plan.push_back(mk(c_E_CALL1, 1'b0, 1'b0));
            end else begin
                s.o = c_E_RET0;
                plan.push_back(mk(c_E_RET1, 1'b0, 1'b0));
                if (c_INTR_EN && ir[3:2] == 2'b11)
                    plan.push_back(mk(c_E_RTI2, 1'b0, 1'b1));
                else
                    plan.push_back(mk(c_E_RET2, 1'b0, 1'b0));
            end
        end else if (c_INTR_EN && m_h2 && !m_in_isr && !flow && !st) begin
            s.o = c_E_INT0;
            plan.push_back(mk(c_E_INT1, 1'b0, 1'b0));
            plan.push_back(mk(c_E_RET2, 1'b1, 1'b0));
        end
        e = s.o;
        if (s.set_isr) m_in_isr = 1'b1;
        if (s.clr_isr) m_in_isr = 1'b0;
        // Request seen by the sequencer lags the pin by two cycles.
        m_h2 = m_h1;
        m_h1 = irq;
    endtask

    task automatic do_cycle(input logic [7:0] ir, input logic st, input logic irq,
                            input logic rv);
        logic [12:0] e;
        @(posedge clk);
        #1;
        IR = ir;
        stall_d = st;
        intr_req = irq;
        rst_n = rv;
        if (!rv) begin
            plan.delete();
            m_in_isr = 1'b0;
            m_h1 = 1'b0;
            m_h2 = 1'b0;
            e = 13'd0;
        end else begin
            model_cycle(ir, st, irq, e);
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: got %b expected %b", cyc, act, e);
            end
            cyc++;
        end
    end

    initial begin
        logic irq_lvl;
        #2 rst_n = 1'b0;
        do_cycle(8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        // JMP, CALL, stalled RET
        do_cycle(8'hB1, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(8'hB6, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(8'hB8, 1'b1, 1'b0, 1'b1);
        do_cycle(8'hB8, 1'b1, 1'b0, 1'b1);
        do_cycle(8'hB8, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        // Interrupt pulse, then held request blocked until RTI
        do_cycle(8'h00, 1'b0, 1'b1, 1'b1);
        repeat (5) do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        repeat (6) do_cycle(8'h00, 1'b0, 1'b1, 1'b1);
        do_cycle(8'hBC, 1'b0, 1'b1, 1'b1);
        repeat (8) do_cycle(8'h00, 1'b0, 1'b1, 1'b1);
        do_cycle(8'hBC, 1'b0, 1'b0, 1'b1);
        repeat (4) do_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        // Reset during RET_WAIT
        do_cycle(8'hB8, 1'b0, 1'b0, 1'b1);
        do_cycle(8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) do_cycle(8'h00, 1'b0, 1'b0, 1'b1);

        irq_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ir;
            if ($urandom_range(0, 19) == 0) irq_lvl = ~irq_lvl;
            if ($urandom_range(0, 9) < 4)
                ir = {4'hB, 4'($urandom_range(0, 15))};
            else
                ir = 8'($urandom_range(0, 255));
            do_cycle(ir, ($urandom_range(0, 4) == 0), irq_lvl,
                     ($urandom_range(0, 299) != 0));
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
